// File: rtl/memory_bist_pkg.sv
// memory_bist_pkg
//   Shared definitions for the memory BIST controller: memory geometry,
//   controller state encoding, LFSR seed and tap positions, and the LFSR
//   next-state helper used by both the LFSR sub-module and the controller.
package memory_bist_pkg;

    localparam int MEM_DEPTH = 16;
    localparam int MEM_AW    = 4;
    localparam int MEM_DW    = 16;

    localparam logic [MEM_DW-1:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // Fibonacci feedback taps: fb = s[15] ^ s[13] ^ s[12] ^ s[10]
    localparam int LFSR_TAP_A = 15;
    localparam int LFSR_TAP_B = 13;
    localparam int LFSR_TAP_C = 12;
    localparam int LFSR_TAP_D = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } bist_state_t;

    function automatic logic [MEM_DW-1:0] lfsr_step(input logic [MEM_DW-1:0] s);
        return {s[MEM_DW-2:0],
                s[LFSR_TAP_A] ^ s[LFSR_TAP_B] ^ s[LFSR_TAP_C] ^ s[LFSR_TAP_D]};
    endfunction

    // An all-zero seed would lock the LFSR at zero, so it is substituted.
    function automatic logic [MEM_DW-1:0] effective_seed(input logic [MEM_DW-1:0] s);
        return (s == '0) ? LFSR_DEFAULT_SEED : s;
    endfunction

endpackage

// File: rtl/memory_bist_if.sv
// memory_bist_if
//   Port bundle between the BIST controller and the 16x16 memory.
//   master : controller side (drives address, write data and controls)
//   slave  : memory side (returns read data)
//   Signals:
//     mem_addr_in  [3:0]  word address
//     mem_data_in  [15:0] write data
//     mem_wr_en           1 = write, 0 = read
//     mem_op_en           operation enable
//     mem_cs              chip select
//     mem_data_out [15:0] read data, valid RD_LAT cycles after a read request
interface memory_bist_if;
    import memory_bist_pkg::*;

    logic [MEM_AW-1:0] mem_addr_in;
    logic [MEM_DW-1:0] mem_data_in;
    logic              mem_wr_en;
    logic              mem_op_en;
    logic              mem_cs;
    logic [MEM_DW-1:0] mem_data_out;

    modport master (
        output mem_addr_in,
        output mem_data_in,
        output mem_wr_en,
        output mem_op_en,
        output mem_cs,
        input  mem_data_out
    );

    modport slave (
        input  mem_addr_in,
        input  mem_data_in,
        input  mem_wr_en,
        input  mem_op_en,
        input  mem_cs,
        output mem_data_out
    );

endinterface

// File: rtl/memory_bist_lfsr16.sv
// bist_lfsr16
//   16-bit Fibonacci LFSR pattern generator. Load has priority over advance
//   so the controller can rewind to the seed between the write and read
//   phases.
//   Ports:
//     clk, reset_n    clock, async active-low reset
//     load, load_val  synchronous load of a new state
//     advance         step the LFSR by one
//     lfsr_state      current LFSR value
module bist_lfsr16
    import memory_bist_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [MEM_DW-1:0] load_val,
    input  logic              advance,
    output logic [MEM_DW-1:0] lfsr_state
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_state <= '0;
        end else if (load) begin
            lfsr_state <= load_val;
        end else if (advance) begin
            lfsr_state <= lfsr_step(lfsr_state);
        end
    end

endmodule

// File: rtl/memory_bist.sv
// memory_bist_ctrl
//   Write-then-readback self test for the 16x16 memory. Writes an LFSR
//   pattern to every word, reads every word back, and compares the returned
//   data against the regenerated pattern after RD_LAT cycles.
//   Parameters:
//     RD_LAT           memory read latency in cycles (1..4)
//   Ports:
//     clk, reset_n     clock, async active-low reset
//     start            run request, sampled only in IDLE
//     seed             pattern seed, zero is replaced by 16'hACE1
//     mem              memory port bundle (master side)
//     busy             high from the first write through the last drain cycle
//     done             one-cycle end-of-test pulse
//     pass             no mismatches in the last run
//     fail_count       mismatching words, saturating at 16
//     first_fail_addr  address of the first mismatching word
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | memory controls low, waiting for start
//   ST_WRITE | writing pattern word cnt to address cnt
//   ST_READ  | requesting read of address cnt, expected word enters pipe
//   ST_DRAIN | controls low, last RD_LAT read results being compared
//   ST_DONE  | done pulse, pass/fail summary presented
module memory_bist_ctrl
    import memory_bist_pkg::*;
#(
    parameter int RD_LAT = 1
)
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [MEM_DW-1:0] seed,
    memory_bist_if.master     mem,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [4:0]        fail_count,
    output logic [MEM_AW-1:0] first_fail_addr
);

    localparam logic [MEM_AW-1:0] LAST_ADDR  = MEM_AW'(MEM_DEPTH - 1);
    localparam logic [MEM_AW-1:0] DRAIN_LAST = MEM_AW'(RD_LAT - 1);
    localparam logic [4:0]        FAIL_MAX   = 5'(MEM_DEPTH);

    bist_state_t       state;
    logic [MEM_AW-1:0] cnt;
    logic [MEM_DW-1:0] seed_q;
    logic [MEM_DW-1:0] seed_eff;

    logic              lfsr_load;
    logic              lfsr_adv;
    logic [MEM_DW-1:0] lfsr_load_val;
    logic [MEM_DW-1:0] lfsr_q;

    // Expect pipeline: stage RD_LAT-1 lines up with mem_data_out.
    logic [RD_LAT-1:0] pipe_vld;
    logic [MEM_DW-1:0] pipe_data [RD_LAT];
    logic [MEM_AW-1:0] pipe_addr [RD_LAT];

    logic              mismatch;
    logic [4:0]        fail_count_nxt;

    bist_lfsr16 u_lfsr (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (lfsr_load),
        .load_val   (lfsr_load_val),
        .advance    (lfsr_adv),
        .lfsr_state (lfsr_q)
    );

    always_comb begin
        seed_eff      = effective_seed(seed);
        lfsr_load     = 1'b0;
        lfsr_adv      = 1'b0;
        lfsr_load_val = seed_q;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    lfsr_load     = 1'b1;
                    lfsr_load_val = seed_eff;
                end
            end
            ST_WRITE: begin
                // Rewind at the end of the write phase so reads regenerate
                // the same sequence from word 0.
                if (cnt == LAST_ADDR) lfsr_load = 1'b1;
                else                  lfsr_adv  = 1'b1;
            end
            ST_READ: lfsr_adv = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        mismatch = pipe_vld[RD_LAT-1] && (mem.mem_data_out != pipe_data[RD_LAT-1]);
        fail_count_nxt = fail_count;
        if (mismatch && (fail_count != FAIL_MAX)) fail_count_nxt = fail_count + 5'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_data[i] <= '0;
                pipe_addr[i] <= '0;
            end
        end else begin
            pipe_vld[0]  <= (state == ST_READ);
            pipe_data[0] <= lfsr_q;
            pipe_addr[0] <= cnt;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_data[i] <= pipe_data[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            seed_q          <= '0;
            mem.mem_addr_in <= '0;
            mem.mem_data_in <= '0;
            mem.mem_wr_en   <= 1'b0;
            mem.mem_op_en   <= 1'b0;
            mem.mem_cs      <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            fail_count      <= '0;
            first_fail_addr <= '0;
        end else begin
            if (mismatch) begin
                fail_count <= fail_count_nxt;
                if (fail_count == '0) first_fail_addr <= pipe_addr[RD_LAT-1];
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state           <= ST_WRITE;
                        cnt             <= '0;
                        seed_q          <= seed_eff;
                        fail_count      <= '0;
                        first_fail_addr <= '0;
                        pass            <= 1'b0;
                        busy            <= 1'b1;
                        mem.mem_cs      <= 1'b1;
                        mem.mem_op_en   <= 1'b1;
                        mem.mem_wr_en   <= 1'b1;
                        mem.mem_addr_in <= '0;
                        mem.mem_data_in <= seed_eff;
                    end
                end
                ST_WRITE: begin
                    if (cnt == LAST_ADDR) begin
                        state           <= ST_READ;
                        cnt             <= '0;
                        mem.mem_wr_en   <= 1'b0;
                        mem.mem_addr_in <= '0;
                        mem.mem_data_in <= '0;
                    end else begin
                        cnt             <= cnt + 1'b1;
                        mem.mem_addr_in <= cnt + 1'b1;
                        mem.mem_data_in <= lfsr_step(lfsr_q);
                    end
                end
                ST_READ: begin
                    if (cnt == LAST_ADDR) begin
                        state           <= ST_DRAIN;
                        cnt             <= '0;
                        mem.mem_cs      <= 1'b0;
                        mem.mem_op_en   <= 1'b0;
                        mem.mem_addr_in <= '0;
                    end else begin
                        cnt             <= cnt + 1'b1;
                        mem.mem_addr_in <= cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (cnt == DRAIN_LAST) begin
                        state <= ST_DONE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // Include a mismatch on the final compare, which
                        // lands on this same edge.
                        pass  <= (fail_count_nxt == '0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_bist_ctrl.sv
module tb_memory_bist_ctrl;
    import memory_bist_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1_n, rst3_n, start1, start3;
    logic [15:0] seed;
    logic        busy1, done1, pass1, busy3, done3, pass3;
    logic [4:0]  fc1, fc3;
    logic [3:0]  ffa1, ffa3;

    memory_bist_if m1();
    memory_bist_if m3();

    memory_bist_ctrl #(.RD_LAT(1)) dut1 (
        .clk(clk), .reset_n(rst1_n), .start(start1), .seed(seed), .mem(m1),
        .busy(busy1), .done(done1), .pass(pass1), .fail_count(fc1), .first_fail_addr(ffa1)
    );

    memory_bist_ctrl #(.RD_LAT(3)) dut3 (
        .clk(clk), .reset_n(rst3_n), .start(start3), .seed(seed), .mem(m3),
        .busy(busy3), .done(done3), .pass(pass3), .fail_count(fc3), .first_fail_addr(ffa3)
    );

    // Behavioural memories with read fault injection.
    // fmode: 0 clean, 1 flip bit 0 at addr 5 and 12, 2 stuck at zero, 3 xor fmask[addr]
    int          fmode = 0;
    logic [15:0] fmask [16];
    logic [15:0] mem1 [16];
    logic [15:0] mem3 [16];
    logic [15:0] r1;
    logic [15:0] r3 [3];

    function automatic logic [15:0] rd_xform(input logic [3:0] a, input logic [15:0] v);
        case (fmode)
            1:       return (a == 4'd5 || a == 4'd12) ? (v ^ 16'h0001) : v;
            2:       return 16'h0000;
            3:       return v ^ fmask[a];
            default: return v;
        endcase
    endfunction

    always @(posedge clk) begin
        if (m1.mem_cs && m1.mem_op_en) begin
            if (m1.mem_wr_en) mem1[m1.mem_addr_in] <= m1.mem_data_in;
            else              r1 <= rd_xform(m1.mem_addr_in, mem1[m1.mem_addr_in]);
        end
    end
    assign m1.mem_data_out = r1;

    always @(posedge clk) begin
        if (m3.mem_cs && m3.mem_op_en) begin
            if (m3.mem_wr_en) mem3[m3.mem_addr_in] <= m3.mem_data_in;
            else              r3[0] <= rd_xform(m3.mem_addr_in, mem3[m3.mem_addr_in]);
        end
        r3[1] <= r3[0];
        r3[2] <= r3[1];
    end
    assign m3.mem_data_out = r3[2];

    // Observation mux over the two instances.
    logic        sel3;
    logic        s_cs, s_op, s_wr, s_busy, s_done, s_pass;
    logic [3:0]  s_addr, s_ffa;
    logic [15:0] s_din;
    logic [4:0]  s_fc;

    always_comb begin
        if (sel3) begin
            s_cs = m3.mem_cs; s_op = m3.mem_op_en; s_wr = m3.mem_wr_en;
            s_addr = m3.mem_addr_in; s_din = m3.mem_data_in;
            s_busy = busy3; s_done = done3; s_pass = pass3; s_fc = fc3; s_ffa = ffa3;
        end else begin
            s_cs = m1.mem_cs; s_op = m1.mem_op_en; s_wr = m1.mem_wr_en;
            s_addr = m1.mem_addr_in; s_din = m1.mem_data_in;
            s_busy = busy1; s_done = done1; s_pass = pass1; s_fc = fc1; s_ffa = ffa1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: the k-th pattern word is the effective seed stepped k times.
    function automatic logic [15:0] ref_pattern(input logic [15:0] s, input int k);
        logic [15:0] x;
        x = (s == 16'h0000) ? 16'hACE1 : s;
        for (int i = 0; i < k; i++) x = {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
        return x;
    endfunction

    task automatic ref_outcome(input logic [15:0] s, output int efc, output int effa, output bit epass);
        logic [15:0] w;
        efc = 0; effa = 0;
        for (int k = 0; k < 16; k++) begin
            w = ref_pattern(s, k);
            if (rd_xform(4'(k), w) != w) begin
                if (efc == 0) effa = k;
                efc++;
            end
        end
        epass = (efc == 0);
    endtask

    task automatic set_start(input bit u3, input logic v);
        if (u3) start3 = v; else start1 = v;
    endtask

    bit          hold_start = 1'b0;
    logic [15:0] w0, w11;

    // One complete run; returns at the negedge where done is seen (or on timeout).
    task automatic do_run(input string tag, input bit u3, input logic [15:0] s);
        int lat, efc, effa, done_e, wr_n, wr_bad, rd_n, drain_bad;
        bit epass;
        lat = u3 ? 3 : 1;
        sel3 = u3;
        seed = s;
        ref_outcome(s, efc, effa, epass);
        @(negedge clk);
        set_start(u3, 1'b1);
        @(posedge clk);            // edge 0: start accepted
        wr_n = 0; wr_bad = 0; rd_n = 0; drain_bad = 0; done_e = -1; w0 = '0; w11 = '0;
        for (int e = 0; e < 120; e++) begin
            @(negedge clk);        // sampling the cycle after edge e
            if (!hold_start) set_start(u3, 1'b0);
            if (s_cs && s_op && s_wr) begin
                if (s_addr != 4'(wr_n) || s_din != ref_pattern(s, wr_n)) wr_bad++;
                if (wr_n == 0)  w0  = s_din;
                if (wr_n == 11) w11 = s_din;
                wr_n++;
            end
            if (s_cs && s_op && !s_wr) begin
                if (s_addr != 4'(rd_n) || e != 16 + rd_n) wr_bad++;
                rd_n++;
            end
            if (e >= 32 && e < 32 + lat && (s_cs || s_op || s_wr)) drain_bad++;
            if (s_done) begin
                done_e = e;
                break;
            end
        end
        check({tag, "_done_edge"}, done_e, 32 + lat);
        check({tag, "_writes"}, wr_n, 16);
        check({tag, "_reads"}, rd_n, 16);
        check({tag, "_seq_errors"}, wr_bad, 0);
        check({tag, "_drain_ctrl"}, drain_bad, 0);
        check({tag, "_busy_at_done"}, s_busy, 0);
        check({tag, "_fail_count"}, s_fc, efc);
        if (efc != 0) check({tag, "_first_fail"}, s_ffa, effa);
        check({tag, "_pass"}, s_pass, epass);
    endtask

    typedef struct {
        logic [15:0] seed;
        int          mode;
        logic [15:0] exp_w0;
        int          exp_fc;
        int          exp_ffa;
        bit          exp_pass;
    } vec_t;

    vec_t vecs [4];

    initial begin
        bit found, done_seen;

        vecs[0] = '{16'h0001, 0, 16'h0001, 0,  0, 1'b1};
        vecs[1] = '{16'h0000, 0, 16'hACE1, 0,  0, 1'b1};
        vecs[2] = '{16'h0001, 1, 16'h0001, 2,  5, 1'b0};
        vecs[3] = '{16'h0001, 2, 16'h0001, 16, 0, 1'b0};
        for (int a = 0; a < 16; a++) fmask[a] = '0;

        rst1_n = 1'b0; rst3_n = 1'b0; start1 = 1'b0; start3 = 1'b0; seed = '0; sel3 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_dut1_outputs", {m1.mem_addr_in, m1.mem_data_in, m1.mem_wr_en, m1.mem_op_en,
                                   m1.mem_cs, busy1, done1, pass1, fc1, ffa1}, 0);
        check("rst_dut3_outputs", {m3.mem_addr_in, m3.mem_data_in, m3.mem_wr_en, m3.mem_op_en,
                                   m3.mem_cs, busy3, done3, pass3, fc3, ffa3}, 0);
        rst1_n = 1'b1; rst3_n = 1'b1;
        repeat (2) @(negedge clk);

        // Spec-derived table of directed runs on RD_LAT=1.
        for (int i = 0; i < 4; i++) begin
            fmode = vecs[i].mode;
            do_run($sformatf("vec%0d", i), 1'b0, vecs[i].seed);
            check($sformatf("vec%0d_first_wdata", i), w0, vecs[i].exp_w0);
            check($sformatf("vec%0d_tbl_fail_count", i), s_fc, vecs[i].exp_fc);
            if (vecs[i].exp_fc != 0) check($sformatf("vec%0d_tbl_first_fail", i), s_ffa, vecs[i].exp_ffa);
            check($sformatf("vec%0d_tbl_pass", i), s_pass, vecs[i].exp_pass);
            if (vecs[i].seed == 16'h0001) check($sformatf("vec%0d_w11", i), w11, 16'h0801);
            repeat (2) @(negedge clk);
        end

        // Latency sweep: RD_LAT=3, done after edge 35, controls low in drain.
        fmode = 0;
        do_run("lat3", 1'b1, 16'h0001);
        check("lat3_tbl_pass", s_pass, 1);
        repeat (2) @(negedge clk);

        // Randomized runs against the reference model.
        for (int r = 0; r < 10; r++) begin
            fmode = 3;
            for (int a = 0; a < 16; a++)
                fmask[a] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0000;
            do_run($sformatf("rnd%0d", r), 1'($unsigned(r % 2)), (r == 4) ? 16'h0000 : 16'($urandom));
            repeat (1) @(negedge clk);
        end

        // start held high through DONE: next run begins the cycle after IDLE.
        fmode = 0;
        hold_start = 1'b1;
        do_run("held", 1'b0, 16'h00F0);
        @(negedge clk);
        check("held_idle_busy", s_busy, 0);
        @(negedge clk);
        check("held_restart", {s_busy, s_wr, s_addr}, {1'b1, 1'b1, 4'd0});
        start1 = 1'b0;
        hold_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (s_done) begin found = 1'b1; break; end
        end
        check("held_second_done", found, 1);
        check("held_second_pass", s_pass, 1);
        repeat (2) @(negedge clk);

        // Busy behaviour: start pulse mid-run ignored, then reset mid-run.
        fmode = 3;
        for (int a = 0; a < 16; a++) fmask[a] = '0;
        fmask[1] = 16'h0001;
        fmask[2] = 16'h0001;
        sel3 = 1'b0;
        seed = 16'h1234;
        done_seen = 1'b0;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        for (int e = 0; e < 20; e++) begin
            @(negedge clk);
            start1 = (e == 10);
            if (s_done) done_seen = 1'b1;
            if (e == 11) check("busy_start_ignored", {s_wr, s_addr, s_din}, {1'b1, 4'd11, ref_pattern(16'h1234, 11)});
            if (e == 19) check("mid_run_fail_state", {s_fc, s_ffa}, {5'd1, 4'd1});
        end
        rst1_n = 1'b0;
        #1;
        check("rst_mid_ctrl", {m1.mem_wr_en, m1.mem_op_en, m1.mem_cs}, 0);
        check("rst_mid_bus", {m1.mem_addr_in, m1.mem_data_in}, 0);
        check("rst_mid_status", {busy1, done1, pass1, fc1, ffa1}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done1) done_seen = 1'b1;
        end
        rst1_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done1 || busy1) done_seen = 1'b1;
        end
        check("rst_no_done_or_restart", done_seen, 0);
        fmode = 0;
        do_run("post_rst", 1'b0, 16'hBEEF);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
